// File: rtl/alu_result_arbiter_if.sv
// alu_result_arbiter_if: adder/multiplier result inputs, ready throttles and FIFO_OUT write port
interface alu_result_arbiter_if #(
  parameter int DATA_SIZE      = 16,
  parameter int ID_SIZE        = 8,
  parameter int OPERATION_SIZE = 2,
  parameter int FIFO_OUT_WIDTH = DATA_SIZE + ID_SIZE + OPERATION_SIZE
);
  logic                      a_done;
  logic [DATA_SIZE-1:0]      a_result;
  logic [ID_SIZE-1:0]        a_id;
  logic                      m_done;
  logic [DATA_SIZE-1:0]      m_result;
  logic [ID_SIZE-1:0]        m_id;
  logic                      full_out;
  logic                      a_ready_data;
  logic                      m_ready_data;
  logic                      w_en_out;
  logic [FIFO_OUT_WIDTH-1:0] fifo_out_data;
  modport master (
    output a_done, a_result, a_id, m_done, m_result, m_id, full_out,
    input  a_ready_data, m_ready_data, w_en_out, fifo_out_data
  );
  modport slave (
    input  a_done, a_result, a_id, m_done, m_result, m_id, full_out,
    output a_ready_data, m_ready_data, w_en_out, fifo_out_data
  );
endinterface

// File: rtl/alu_result_arbiter.sv
// alu_result_arbiter: round-robin merge of adder/multiplier results into FIFO_OUT; ALU_ARB_DROP_CNT_EN adds drop_cnt
module alu_result_arbiter #(
  parameter int DATA_SIZE      = 16,
  parameter int ID_SIZE        = 8,
  parameter int OPERATION_SIZE = 2,
  parameter int FIFO_OUT_WIDTH = DATA_SIZE + ID_SIZE + OPERATION_SIZE
) (
  input logic clk,
  input logic rst,
  alu_result_arbiter_if.slave bus
`ifdef ALU_ARB_DROP_CNT_EN
  ,
  output logic [7:0] drop_cnt
`endif
);
  typedef enum logic {ADD, MUL} src_e;
  src_e                 last_grant;
  logic                 add_v, mul_v;
  logic [DATA_SIZE-1:0] add_r, mul_r;
  logic [ID_SIZE-1:0]   add_id, mul_id;
  logic                 gnt_add, gnt_mul, a_rdy, m_rdy, a_load, m_load;
  always_comb begin
    gnt_add           = !bus.full_out && add_v && (!mul_v || last_grant == MUL);
    gnt_mul           = !bus.full_out && mul_v && (!add_v || last_grant == ADD);
    a_rdy             = !add_v || gnt_add;
    m_rdy             = !mul_v || gnt_mul;
    a_load            = bus.a_done && a_rdy;
    m_load            = bus.m_done && m_rdy;
    bus.a_ready_data  = a_rdy;
    bus.m_ready_data  = m_rdy;
    bus.w_en_out      = gnt_add || gnt_mul;
    bus.fifo_out_data = gnt_add ? FIFO_OUT_WIDTH'({add_r, add_id, OPERATION_SIZE'(1)}) :
                        gnt_mul ? FIFO_OUT_WIDTH'({mul_r, mul_id, OPERATION_SIZE'(2)}) : '0;
  end
  // a new load wins over the clear of a slot granted in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {add_v, add_r, add_id} <= '0;
      {mul_v, mul_r, mul_id} <= '0;
      last_grant             <= MUL;
    end else begin
      if (a_load) {add_v, add_r, add_id} <= {1'b1, bus.a_result, bus.a_id};
      else if (gnt_add) add_v <= 1'b0;
      if (m_load) {mul_v, mul_r, mul_id} <= {1'b1, bus.m_result, bus.m_id};
      else if (gnt_mul) mul_v <= 1'b0;
      if (gnt_add) last_grant <= ADD;
      else if (gnt_mul) last_grant <= MUL;
    end
  end
`ifdef ALU_ARB_DROP_CNT_EN
  logic [8:0] drop_sum;
  always_comb drop_sum = {1'b0, drop_cnt} + 9'(bus.a_done && !a_rdy) + 9'(bus.m_done && !m_rdy);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_cnt <= '0;
    else drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end
`endif
endmodule

// File: tb/tb_alu_result_arbiter.sv
// tb_alu_result_arbiter: directed and randomized checks against a slot-level reference model
module tb_alu_result_arbiter;
  localparam int DW = 16, IW = 8, OW = 2, FW = DW + IW + OW;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  alu_result_arbiter_if #(.DATA_SIZE(DW), .ID_SIZE(IW), .OPERATION_SIZE(OW), .FIFO_OUT_WIDTH(FW)) bus();
`ifdef ALU_ARB_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif
  alu_result_arbiter #(.DATA_SIZE(DW), .ID_SIZE(IW), .OPERATION_SIZE(OW), .FIFO_OUT_WIDTH(FW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef ALU_ARB_DROP_CNT_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );
  int checks = 0;
  int errors = 0;
  // reference model: source 0 = ADD, 1 = MUL
  logic          mv[2];
  logic [DW-1:0] mr[2];
  logic [IW-1:0] mi[2];
  int            mlast;
  int            mdrop;
  function automatic void model_reset();
    for (int s = 0; s < 2; s++) begin
      mv[s] = 1'b0;
      mr[s] = '0;
      mi[s] = '0;
    end
    mlast = 1;
    mdrop = 0;
  endfunction
  function automatic int pick();
    if (bus.full_out) return -1;
    if (mv[0] && mv[1]) return 1 - mlast;
    if (mv[0]) return 0;
    if (mv[1]) return 1;
    return -1;
  endfunction
  function automatic logic [FW-1:0] exp_word();
    int p = pick();
    if (p < 0) return '0;
    return {mr[p], mi[p], (p == 0) ? 2'b01 : 2'b10};
  endfunction
  function automatic logic exp_ready(int s);
    return !mv[s] || pick() == s;
  endfunction
  function automatic void model_step();
    int p = pick();
    logic r0 = exp_ready(0);
    logic r1 = exp_ready(1);
    if (p >= 0) begin
      mv[p] = 1'b0;
      mlast = p;
    end
    if (bus.a_done) begin
      if (r0) begin mv[0] = 1'b1; mr[0] = bus.a_result; mi[0] = bus.a_id; end
      else mdrop++;
    end
    if (bus.m_done) begin
      if (r1) begin mv[1] = 1'b1; mr[1] = bus.m_result; mi[1] = bus.m_id; end
      else mdrop++;
    end
    if (mdrop > 255) mdrop = 255;
  endfunction
  task automatic drive(input logic ad, input logic [DW-1:0] ar, input logic [IW-1:0] ai,
                       input logic md, input logic [DW-1:0] mres, input logic [IW-1:0] mid,
                       input logic f);
    bus.a_done = ad; bus.a_result = ar; bus.a_id = ai;
    bus.m_done = md; bus.m_result = mres; bus.m_id = mid;
    bus.full_out = f;
    #1;
  endtask
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    bus.a_done = 1'b0;
    bus.m_done = 1'b0;
    #1;
  endtask
  task automatic reset_dut();
    drive(0, '0, '0, 0, '0, '0, 0);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask
  task automatic test_reset();
    drive(0, '0, '0, 0, '0, '0, 0);
    rst = 1'b1;
    model_reset();
    #2;
    checks++;
    if (bus.w_en_out !== 1'b0 || bus.fifo_out_data !== '0 || bus.a_ready_data !== 1'b1 || bus.m_ready_data !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs: w_en=%b data=%h ar=%b mr=%b, want 0 0 1 1", bus.w_en_out, bus.fifo_out_data, bus.a_ready_data, bus.m_ready_data);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.w_en_out !== 1'b0 || bus.fifo_out_data !== '0 || bus.a_ready_data !== 1'b1 || bus.m_ready_data !== 1'b1) begin
        errors++;
        $display("FAIL idle_outputs: w_en=%b data=%h ar=%b mr=%b, want 0 0 1 1", bus.w_en_out, bus.fifo_out_data, bus.a_ready_data, bus.m_ready_data);
      end
      tick();
    end
  endtask
  task automatic test_single_add();
    reset_dut();
    drive(1, 16'h1234, 8'h05, 0, '0, '0, 0);
    tick();
    checks++;
    if (bus.w_en_out !== 1'b1 || bus.fifo_out_data !== {16'h1234, 8'h05, 2'b01}) begin
      errors++;
      $display("FAIL single_add_write: w_en=%b data=%h, want 1 %h", bus.w_en_out, bus.fifo_out_data, {16'h1234, 8'h05, 2'b01});
    end
    tick();
    checks++;
    if (bus.w_en_out !== 1'b0 || bus.fifo_out_data !== '0) begin
      errors++;
      $display("FAIL single_add_idle: w_en=%b data=%h, want 0 0", bus.w_en_out, bus.fifo_out_data);
    end
  endtask
  task automatic test_simultaneous();
    reset_dut();
    for (int rep = 0; rep < 2; rep++) begin
      drive(1, 16'h0011, 8'h01, 1, 16'h0022, 8'h02, 0);
      tick();
      checks++;
      if (bus.w_en_out !== 1'b1 || bus.fifo_out_data !== {16'h0011, 8'h01, 2'b01}) begin
        errors++;
        $display("FAIL simul_first_add rep%0d: w_en=%b data=%h, want 1 %h", rep, bus.w_en_out, bus.fifo_out_data, {16'h0011, 8'h01, 2'b01});
      end
      tick();
      checks++;
      if (bus.w_en_out !== 1'b1 || bus.fifo_out_data !== {16'h0022, 8'h02, 2'b10}) begin
        errors++;
        $display("FAIL simul_second_mul rep%0d: w_en=%b data=%h, want 1 %h", rep, bus.w_en_out, bus.fifo_out_data, {16'h0022, 8'h02, 2'b10});
      end
      tick();
      checks++;
      if (bus.w_en_out !== 1'b0) begin
        errors++;
        $display("FAIL simul_idle rep%0d: w_en=%b, want 0", rep, bus.w_en_out);
      end
    end
  endtask
  task automatic test_backpressure();
    reset_dut();
    drive(1, 16'hAAAA, 8'h10, 1, 16'hBBBB, 8'h20, 1);
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.w_en_out !== 1'b0 || bus.a_ready_data !== 1'b0 || bus.m_ready_data !== 1'b0) begin
        errors++;
        $display("FAIL full_hold cyc%0d: w_en=%b ar=%b mr=%b, want 0 0 0", i, bus.w_en_out, bus.a_ready_data, bus.m_ready_data);
      end
      tick();
    end
    bus.full_out = 1'b0;
    #1;
    checks++;
    if (bus.w_en_out !== 1'b1 || bus.fifo_out_data !== {16'hAAAA, 8'h10, 2'b01}) begin
      errors++;
      $display("FAIL release_add: w_en=%b data=%h, want 1 %h", bus.w_en_out, bus.fifo_out_data, {16'hAAAA, 8'h10, 2'b01});
    end
    tick();
    checks++;
    if (bus.w_en_out !== 1'b1 || bus.fifo_out_data !== {16'hBBBB, 8'h20, 2'b10}) begin
      errors++;
      $display("FAIL release_mul: w_en=%b data=%h, want 1 %h", bus.w_en_out, bus.fifo_out_data, {16'hBBBB, 8'h20, 2'b10});
    end
    tick();
    checks++;
    if (bus.w_en_out !== 1'b0) begin
      errors++;
      $display("FAIL release_idle: w_en=%b, want 0", bus.w_en_out);
    end
  endtask
  task automatic test_streaming();
    reset_dut();
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) drive(1, DW'(i), IW'(i), 0, '0, '0, 0);
      checks++;
      if (bus.a_ready_data !== 1'b1) begin
        errors++;
        $display("FAIL stream_ready cyc%0d: a_ready=%b, want 1", i, bus.a_ready_data);
      end
      if (i > 0) begin
        checks++;
        if (bus.w_en_out !== 1'b1 || bus.fifo_out_data !== {DW'(i - 1), IW'(i - 1), 2'b01}) begin
          errors++;
          $display("FAIL stream_write cyc%0d: w_en=%b data=%h, want 1 %h", i, bus.w_en_out, bus.fifo_out_data, {DW'(i - 1), IW'(i - 1), 2'b01});
        end
      end
      tick();
    end
  endtask
  task automatic test_drop();
    reset_dut();
    drive(1, 16'h5555, 8'h33, 0, '0, '0, 1);
    tick();
    drive(1, 16'h6666, 8'h44, 0, '0, '0, 1);
    tick();
    drive(1, 16'h7777, 8'h55, 0, '0, '0, 1);
    tick();
`ifdef ALU_ARB_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 8'd2) begin
      errors++;
      $display("FAIL drop_count: drop_cnt=%0d, want 2", drop_cnt);
    end
`endif
    bus.full_out = 1'b0;
    #1;
    checks++;
    if (bus.w_en_out !== 1'b1 || bus.fifo_out_data !== {16'h5555, 8'h33, 2'b01}) begin
      errors++;
      $display("FAIL drop_keeps_data: w_en=%b data=%h, want 1 %h", bus.w_en_out, bus.fifo_out_data, {16'h5555, 8'h33, 2'b01});
    end
    tick();
    checks++;
    if (bus.w_en_out !== 1'b0) begin
      errors++;
      $display("FAIL drop_no_extra: w_en=%b, want 0", bus.w_en_out);
    end
  endtask
  task automatic test_reset_mid();
    reset_dut();
    drive(1, 16'hCAFE, 8'h77, 1, 16'hBEEF, 8'h88, 1);
    tick();
    bus.full_out = 1'b0;
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (bus.w_en_out !== 1'b0 || bus.fifo_out_data !== '0 || bus.a_ready_data !== 1'b1 || bus.m_ready_data !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: w_en=%b data=%h ar=%b mr=%b, want 0 0 1 1", bus.w_en_out, bus.fifo_out_data, bus.a_ready_data, bus.m_ready_data);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tick();
    checks++;
    if (bus.w_en_out !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_discard: w_en=%b, want 0", bus.w_en_out);
    end
  endtask
  task automatic test_random();
    reset_dut();
    for (int i = 0; i < 400; i++) begin
      drive(logic'($urandom_range(0, 9) < 6), DW'($urandom), IW'($urandom),
            logic'($urandom_range(0, 9) < 6), DW'($urandom), IW'($urandom),
            logic'($urandom_range(0, 9) < 3));
      checks++;
      if (bus.w_en_out !== (pick() >= 0) || bus.fifo_out_data !== exp_word() ||
          bus.a_ready_data !== exp_ready(0) || bus.m_ready_data !== exp_ready(1)) begin
        errors++;
        $display("FAIL random cyc%0d: w_en=%b data=%h ar=%b mr=%b, want %b %h %b %b", i, bus.w_en_out,
                 bus.fifo_out_data, bus.a_ready_data, bus.m_ready_data, pick() >= 0, exp_word(), exp_ready(0), exp_ready(1));
      end
`ifdef ALU_ARB_DROP_CNT_EN
      checks++;
      if (drop_cnt !== 8'(mdrop)) begin
        errors++;
        $display("FAIL random_drop cyc%0d: drop_cnt=%0d, want %0d", i, drop_cnt, mdrop);
      end
`endif
      tick();
    end
  endtask
  initial begin
    test_reset();
    test_single_add();
    test_simultaneous();
    test_backpressure();
    test_streaming();
    test_drop();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_result_arbiter.md
Name: alu_result_arbiter

Overview:
- Output-side counterpart of the ALU input control unit.
- Captures single-cycle result pulses from the adder and the multiplier into one-deep holding slots, one slot per source.
- Arbitrates the two slots round-robin into FIFO_OUT and throttles each ALU unit through its ready signal.
- Sits between the ALU and FIFO_OUT in the ALU top level.

Parameters:
- DATA_SIZE, 16, result width for both adder and multiplier.
- ID_SIZE, 8, transaction ID width carried with each result.
- OPERATION_SIZE, 2, operation code width written to FIFO_OUT.
- FIFO_OUT_WIDTH, DATA_SIZE+ID_SIZE+OPERATION_SIZE, FIFO_OUT word width; packing is {result, id, op}.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- a_done  in  1  adder result valid, single-cycle pulse.
- a_result  in  DATA_SIZE  adder result.
- a_id  in  ID_SIZE  adder transaction ID.
- m_done  in  1  multiplier result valid, single-cycle pulse.
- m_result  in  DATA_SIZE  multiplier result.
- m_id  in  ID_SIZE  multiplier transaction ID.
- full_out  in  1  FIFO_OUT full.
- a_ready_data  out  1  adder slot can accept a result.
- m_ready_data  out  1  multiplier slot can accept a result.
- w_en_out  out  1  FIFO_OUT write enable.
- fifo_out_data  out  FIFO_OUT_WIDTH  FIFO_OUT write word.

Behaviour:
- State:
  - Two slots, ADD and MUL. Each slot holds valid, result and id.
  - One round-robin pointer, last_grant, with values ADD or MUL.
- Reset:
  - rst asserts asynchronously: both slots invalid, result/id registers 0, last_grant = MUL (so ADD wins the first tie).
  - Outputs during reset: w_en_out=0, fifo_out_data=0, a_ready_data=1, m_ready_data=1.
- Ready signals:
  - a_ready_data = !slot_add.valid | grant_add.
  - m_ready_data = !slot_mul.valid | grant_mul.
  - Both are combinational from registers, grants and full_out.
- Grant (combinational; no grant when full_out=1):
  - Only one slot valid: that slot is granted.
  - Both slots valid: grant goes to the slot that is not last_grant.
- Write:
  - w_en_out = grant_add | grant_mul.
  - fifo_out_data = {slot.result, slot.id, op} of the granted slot; op = 2'b01 for ADD, 2'b10 for MUL.
  - fifo_out_data = 0 when w_en_out=0.
- Rising edge of clk:
  - A granted slot clears valid, and last_grant updates to that slot.
  - a_done=1 loads slot_add with {1, a_result, a_id}. This load overrides a same-cycle clear (back-to-back throughput of 1 per cycle per source).
  - m_done behaves the same for slot_mul.
- Latency: done sampled at edge k; w_en_out can be high in cycle k→k+1; FIFO_OUT write occurs at edge k+1 at the earliest.
- Throughput: at most one FIFO_OUT write per cycle. With both sources streaming, the two sources alternate.
- Full:
  - While full_out=1: no write, slots hold, last_grant holds, ready low for occupied slots.
  - When full_out deasserts, draining resumes the same cycle, with no lost or duplicated words.
- Protocol violation: a done pulse arriving while its slot is valid and not granted is dropped. Slot contents are unchanged.
- Simultaneous done pulses on both sources: both slots load independently.
- Reset mid-operation: any pending slot data is discarded; no partial write is issued.

Optional Feature:
- Macro: ALU_ARB_DROP_CNT_EN.
- Defined:
  - Adds output port drop_cnt, 8 bits, reset 0.
  - drop_cnt increments by 1 for each dropped done pulse.
  - Increments by 2 when both sources drop in the same cycle.
  - Saturates at 8'hFF.
- Undefined: no port is added and no counter logic is present; drops are silent.

Test Plan:
- Reset, then idle: w_en_out=0, fifo_out_data=0, both ready=1. Assert rst mid-run with both slots full → w_en_out=0 immediately, ready=1.
- Single add: a_done with a_result=16'h1234, a_id=8'h05, full_out=0 → next cycle w_en_out=1 with fifo_out_data={16'h1234, 8'h05, 2'b01}; following cycle w_en_out=0.
- Simultaneous done after reset: ADD {16'h0011, 8'h01} and MUL {16'h0022, 8'h02} → writes in order ADD then MUL on consecutive cycles. A repeat of the same pair → ADD then MUL again (pointer alternates).
- Backpressure: full_out=1 while slots hold ADD 16'hAAAA and MUL 16'hBBBB → no writes, both ready=0 for 5 cycles. Release full_out → two writes in round-robin order with correct data.
- Streaming: a_done every cycle for 8 cycles with results 0..7, full_out=0 → 8 consecutive writes of 0..7 with op=01, a_ready_data constantly 1.
- Drop (ALU_ARB_DROP_CNT_EN): full_out=1, slot_add valid, two more a_done pulses → slot_add keeps its original data, drop_cnt=2. Without the macro: same data behaviour and no drop_cnt port.
